// File: rtl/bcd_digit_counter.sv
// Multi-digit BCD counter with prescaler, clear, parallel load and wrap carry.
// Optional down-counting (adds port `down`) is enabled by defining BCD_DOWN_EN.
module bcd_digit_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
`ifdef BCD_DOWN_EN
  input  logic                  down,
`endif
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  carry
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                tick_q, tick_d;
  logic                carry_q, carry_d;

  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic                prop;
  logic                step;
  logic                count_down;

`ifdef BCD_DOWN_EN
  assign count_down = down;
`else
  assign count_down = 1'b0;
`endif

  assign step = enable && (presc_q == PRESC_LAST);

  // Ripple increment/decrement; prop left set after the top digit means wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    stepped = bcd_q;
    prop    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (prop) begin
        if (count_down) begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            prop              = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            prop              = 1'b0;
          end
        end
      end
    end
  end

  // Illegal load nibbles (10-15) are replaced by 0 so bcd stays legal.
  always_comb begin
    loaded = '0;
    for (int i = 0; i < DIGITS; i++) begin
      loaded[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
    end
  end

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clear) begin
      presc_d = '0;
      bcd_d   = '0;
    end else if (load) begin
      presc_d = '0;
      bcd_d   = loaded;
    end else if (enable) begin
      if (step) begin
        presc_d = '0;
        bcd_d   = stepped;
        tick_d  = 1'b1;
        carry_d = prop;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bcd   = bcd_q;
  assign tick  = tick_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Self-checking bench: two 2-digit counters (PRESCALE=1 and PRESCALE=3) share inputs
// and are compared against an integer-count reference model.
module tb_bcd_digit_counter;

  logic       clock = 1'b0;
  logic       reset, enable, clear, load;
  logic [7:0] load_value;
`ifdef BCD_DOWN_EN
  logic       down;
`endif
  logic [7:0] bcd1, bcd3;
  logic       tick1, carry1, tick3, carry3;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: count held as a plain integer 0..99, phase as an integer.
  int   m_cnt[2];
  int   m_ph[2];
  logic m_tick[2];
  logic m_carry[2];

  always #5 clock = ~clock;

  bcd_digit_counter #(.DIGITS(2), .PRESCALE(1)) dut_p1 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
`ifdef BCD_DOWN_EN
    .down(down),
`endif
    .load_value(load_value), .bcd(bcd1), .tick(tick1), .carry(carry1));

  bcd_digit_counter #(.DIGITS(2), .PRESCALE(3)) dut_p3 (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .load(load),
`ifdef BCD_DOWN_EN
    .down(down),
`endif
    .load_value(load_value), .bcd(bcd3), .tick(tick3), .carry(carry3));

  function automatic int pre(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] to_bcd(int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [9:0] exp_obs(int k);
    return {to_bcd(m_cnt[k]), m_tick[k], m_carry[k]};
  endfunction

  function automatic int load_to_int(logic [7:0] v);
    int hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    int lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic model_edge();
    bit dn = 1'b0;
`ifdef BCD_DOWN_EN
    dn = down;
`endif
    for (int k = 0; k < 2; k++) begin
      m_tick[k]  = 1'b0;
      m_carry[k] = 1'b0;
      if (reset || clear) begin
        m_cnt[k] = 0;
        m_ph[k]  = 0;
      end else if (load) begin
        m_cnt[k] = load_to_int(load_value);
        m_ph[k]  = 0;
      end else if (enable) begin
        if (m_ph[k] == pre(k) - 1) begin
          m_ph[k]   = 0;
          m_tick[k] = 1'b1;
          if (dn) begin
            m_carry[k] = (m_cnt[k] == 0);
            m_cnt[k]   = (m_cnt[k] + 99) % 100;
          end else begin
            m_carry[k] = (m_cnt[k] == 99);
            m_cnt[k]   = (m_cnt[k] + 1) % 100;
          end
        end else begin
          m_ph[k] = m_ph[k] + 1;
        end
      end
    end
  endtask

  // Inputs are changed at the falling edge; outputs are sampled at the next falling edge.
  task automatic clk_edge();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; load = 1'b1; clear = 1'b0; load_value = 8'h47;
`ifdef BCD_DOWN_EN
    down = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1} !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_p1 edge %0d: got bcd=%h tick=%b carry=%b, want 00/0/0", i, bcd1, tick1, carry1);
      end
      n_checks++;
      if ({bcd3, tick3, carry3} !== 10'h000) begin
        n_fail++;
        $display("FAIL reset_p3 edge %0d: got bcd=%h tick=%b carry=%b, want 00/0/0", i, bcd3, tick3, carry3);
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_count_wrap();
    enable = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1} !== {to_bcd(i % 100), 1'b1, 1'(i == 100)}) begin
        n_fail++;
        $display("FAIL count_wrap_p1 step %0d: got bcd=%h tick=%b carry=%b, want %h/1/%b",
                 i, bcd1, tick1, carry1, to_bcd(i % 100), i == 100);
      end
      n_checks++;
      if ({bcd3, tick3, carry3} !== exp_obs(1)) begin
        n_fail++;
        $display("FAIL count_wrap_p3 step %0d: got %h want %h", i, {bcd3, tick3, carry3}, exp_obs(1));
      end
    end
  endtask

  task automatic test_prescaler();
    clear = 1'b1; clk_edge(); clear = 1'b0;
    n_checks++;
    if ({bcd3, tick3, carry3} !== 10'h000) begin
      n_fail++;
      $display("FAIL presc_clear: got bcd=%h tick=%b carry=%b, want 00/0/0", bcd3, tick3, carry3);
    end
    enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd3, tick3} !== {to_bcd(i / 3), 1'(i % 3 == 0)}) begin
        n_fail++;
        $display("FAIL presc_step edge %0d: got bcd=%h tick=%b, want %h/%b", i, bcd3, tick3, to_bcd(i / 3), i % 3 == 0);
      end
    end
    clk_edge();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd3, tick3} !== {8'h03, 1'b0}) begin
        n_fail++;
        $display("FAIL presc_hold cycle %0d: got bcd=%h tick=%b, want 03/0", i, bcd3, tick3);
      end
    end
    enable = 1'b1;
    clk_edge();
    n_checks++;
    if ({bcd3, tick3} !== {8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL presc_resume1: got bcd=%h tick=%b, want 03/0", bcd3, tick3);
    end
    clk_edge();
    n_checks++;
    if ({bcd3, tick3} !== {8'h04, 1'b1}) begin
      n_fail++;
      $display("FAIL presc_resume2: got bcd=%h tick=%b, want 04/1", bcd3, tick3);
    end
    for (int i = 0; i < 300; i++) begin
      enable = 1'($urandom_range(0, 3) != 0);
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1, bcd3, tick3, carry3} !== {exp_obs(0), exp_obs(1)}) begin
        n_fail++;
        $display("FAIL presc_random cycle %0d: got %h/%h want %h/%h", i,
                 {bcd1, tick1, carry1}, {bcd3, tick3, carry3}, exp_obs(0), exp_obs(1));
      end
    end
  endtask

  task automatic test_load();
    enable = 1'b0; load = 1'b1; load_value = 8'h47;
    clk_edge();
    n_checks++;
    if ({bcd1, bcd3} !== 16'h4747) begin
      n_fail++;
      $display("FAIL load_47: got %h/%h want 47/47", bcd1, bcd3);
    end
    load_value = 8'hA5;
    clk_edge();
    n_checks++;
    if ({bcd1, bcd3} !== 16'h0505) begin
      n_fail++;
      $display("FAIL load_A5: got %h/%h want 05/05", bcd1, bcd3);
    end
    enable = 1'b1; load_value = 8'h38;
    clk_edge();
    n_checks++;
    if ({bcd1, tick1, carry1} !== {8'h38, 2'b00}) begin
      n_fail++;
      $display("FAIL load_on_step: got bcd=%h tick=%b carry=%b want 38/0/0", bcd1, tick1, carry1);
    end
    for (int i = 0; i < 40; i++) begin
      load       = 1'($urandom_range(0, 1));
      enable     = 1'($urandom_range(0, 1));
      load_value = 8'($urandom);
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1, bcd3, tick3, carry3} !== {exp_obs(0), exp_obs(1)}) begin
        n_fail++;
        $display("FAIL load_random %0d lv=%h: got %h/%h want %h/%h", i, load_value,
                 {bcd1, tick1, carry1}, {bcd3, tick3, carry3}, exp_obs(0), exp_obs(1));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_clear_vs_load();
    load = 1'b1; load_value = 8'h63; enable = 1'b0;
    clk_edge();
    n_checks++;
    if ({bcd1, bcd3} !== 16'h6363) begin
      n_fail++;
      $display("FAIL clr_pre_load: got %h/%h want 63/63", bcd1, bcd3);
    end
    clear = 1'b1; load_value = 8'h12; enable = 1'b1;
    clk_edge();
    n_checks++;
    if ({bcd1, tick1, carry1, bcd3, tick3, carry3} !== 20'h0) begin
      n_fail++;
      $display("FAIL clear_over_load: got %h/%b/%b %h/%b/%b want all 0", bcd1, tick1, carry1, bcd3, tick3, carry3);
    end
    clear = 1'b0; load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd3, tick3} !== {to_bcd(i / 3), 1'(i == 3)}) begin
        n_fail++;
        $display("FAIL clear_restart edge %0d: got bcd=%h tick=%b want %h/%b", i, bcd3, tick3, to_bcd(i / 3), i == 3);
      end
    end
  endtask

`ifdef BCD_DOWN_EN
  task automatic test_down();
    logic [9:0] want [3];
    want[0] = {8'h00, 2'b10};
    want[1] = {8'h99, 2'b11};
    want[2] = {8'h98, 2'b10};
    load = 1'b1; load_value = 8'h01; enable = 1'b0;
    clk_edge();
    load = 1'b0; enable = 1'b1; down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1} !== want[i]) begin
        n_fail++;
        $display("FAIL down step %0d: got %h want %h", i, {bcd1, tick1, carry1}, want[i]);
      end
    end
    down = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset      = 1'($urandom_range(0, 63) == 0);
      clear      = 1'($urandom_range(0, 31) == 0);
      load       = 1'($urandom_range(0, 15) == 0);
      enable     = 1'($urandom_range(0, 3) != 0);
      load_value = 8'($urandom);
`ifdef BCD_DOWN_EN
      down       = 1'($urandom_range(0, 1));
`endif
      clk_edge();
      n_checks++;
      if ({bcd1, tick1, carry1, bcd3, tick3, carry3} !== {exp_obs(0), exp_obs(1)}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h/%h want %h/%h", i,
                 {bcd1, tick1, carry1}, {bcd3, tick3, carry3}, exp_obs(0), exp_obs(1));
      end
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0; load_value = 8'h00;
`ifdef BCD_DOWN_EN
    down = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ph[k] = 0; m_tick[k] = 1'b0; m_carry[k] = 1'b0;
    end
    @(negedge clock);
    test_reset();
    test_count_wrap();
    test_prescaler();
    test_load();
    test_clear_vs_load();
`ifdef BCD_DOWN_EN
    test_down();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_counter.md
Name: bcd_digit_counter

Overview:
- Multi-digit synchronous BCD counter that generates the digit values consumed by the BCD-to-7-segment translator. Each 4-bit digit output drives one translator instance directly.
- An internal prescaler sets the count rate from the system clock.
- Supports synchronous clear, parallel load and wrap-around carry for cascading.
- Outputs are only ever legal BCD codes (0-9), so the translator never receives codes 10-15.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1-8.
- PRESCALE, 50, enabled clock cycles per count step; legal range 1-65535. PRESCALE=1 counts on every enabled cycle.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, the prescaler advances; when low, the prescaler and digits hold.
- clear  input  1  synchronous clear of digits and prescaler.
- load  input  1  synchronous parallel load.
- load_value  input  4*DIGITS  load data; digit i is bits [4i+3:4i], and digit 0 is the least significant.
- bcd  output  4*DIGITS  current count, same packing as load_value; each nibble is always 0-9.
- tick  output  1  one-cycle pulse, registered, high in the cycle after the prescaler's step edge.
- carry  output  1  one-cycle pulse, registered, high in the cycle in which bcd shows the wrapped value.

Behaviour:
- Reset:
  - On a rising edge of clock with reset=1: bcd=0, prescaler=0, tick=0, carry=0.
  - reset dominates all other inputs, including mid-count and mid-load.
- Priority on each edge: reset > clear > load > count step > hold.
- clear=1:
  - bcd=0, prescaler=0, tick=0, carry=0.
  - Ignores enable and load.
- load=1 (clear=0):
  - Each nibble of load_value is copied to bcd.
  - Any nibble greater than 9 is loaded as 0.
  - Prescaler resets to 0; tick=0, carry=0.
  - Ignores enable.
- Prescaler:
  - When enable=1 and prescaler==PRESCALE-1: this edge is a step edge. Prescaler returns to 0.
  - When enable=1 otherwise: prescaler increments by 1.
  - When enable=0: prescaler holds.
  - Prescaler width is clog2(PRESCALE), minimum 1 bit.
- Step edge:
  - tick=1 for exactly one cycle.
  - Digit 0 increments. A digit at 9 becomes 0 and propagates an increment into the next digit (ripple within the same edge).
  - Latency: the new bcd value is visible in the cycle after the step edge, together with tick.
- Wrap:
  - When every digit is 9 at a step edge, bcd becomes all zeros and carry=1 for that one cycle.
  - carry is never asserted without tick.
- On non-step edges, tick=0 and carry=0.
- enable deasserted mid-count freezes the prescaler phase. Re-enabling resumes from the same phase, so the number of enabled cycles per step stays exactly PRESCALE.
- load and clear on the same edge as a would-be step: load or clear wins, and no tick or carry is produced.
- All outputs are registered. There is no combinational path from any input to any output.

Optional Feature:
- Macro: BCD_DOWN_EN.
- When defined:
  - Adds input port down (1 bit).
  - On step edges with down=1, digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All-zero decrements to all-nines, with carry=1 for one cycle (carry then signals borrow).
  - down is sampled only on step edges; down=0 behaves as the base counter.
- When undefined:
  - No down port exists.
  - The counter counts up only, exactly as described above.

Test Plan:
- Reset: DIGITS=2, PRESCALE=1, hold reset=1 with enable=1 and load=1 for 3 edges -> bcd=8'h00, tick=0, carry=0 throughout.
- Count and wrap: DIGITS=2, PRESCALE=1, enable=1 for 100 edges from 00 -> bcd steps 00,01..09,10..99,00. carry=1 only in the cycle bcd returns to 00. tick is high on every one of those cycles.
- Prescaler: PRESCALE=3, enable=1 -> bcd changes every 3rd edge with tick high for 1 cycle. Then drop enable for 5 cycles after 1 enabled cycle -> no change; after re-enable, the next step arrives 2 enabled cycles later.
- Load: DIGITS=2, load_value=8'h47 -> bcd=47 on the next cycle. Then load_value=8'hA5 -> bcd=05. load asserted on a step edge -> bcd=load value, tick=0.
- Clear vs. load: clear=1 and load=1 on the same edge with bcd=8'h63 -> bcd=00, prescaler restarts from 0.
- Down (BCD_DOWN_EN, DIGITS=2, PRESCALE=1): load 8'h01, down=1 -> bcd 00, then 99 with carry=1 in that cycle, then 98.
